// File: rtl/sample_capture_ram.sv
// sample_capture_ram: arm/trigger capture buffer writing a sample stream into RAM, with an independent registered read port
module sample_capture_ram #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     arm_i,
    input  logic                     trig_i,
    input  logic                     din_valid_i,
    input  logic [DATA_WIDTH-1:0]    din_i,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]    dout_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADDRESS_WIDTH:0]   wr_count_o
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] FULL = 1'b1 << ADDRESS_WIDTH;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH:0]   wr_count_q, wr_count_d;
    logic                     busy_q, done_q;
    logic [DATA_WIDTH-1:0]    dout_q;
    logic                     wr_en, last_wr;

    // Next-state logic: a write happens on the trigger cycle or any valid cycle while capturing
    always_comb begin
        wr_en      = din_valid_i && ((state_q == ARMED && trig_i) || state_q == CAPTURE);
        last_wr    = &wr_ptr_q;
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        case (state_q)
            IDLE, DONE: if (arm_i) begin
                state_d    = ARMED;
                wr_ptr_d   = '0;
                wr_count_d = '0;
            end
            ARMED:   if (trig_i) state_d = (wr_en && last_wr) ? DONE : CAPTURE;
            CAPTURE: if (wr_en && last_wr) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (wr_en) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            wr_count_d = (wr_count_q == FULL) ? wr_count_q : wr_count_q + 1'b1;
        end
    end

    // Capture FSM state, pointers and registered status flags
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            busy_q     <= (state_d == ARMED) || (state_d == CAPTURE);
            done_q     <= (state_d == DONE);
        end
    end

    // Sample RAM write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= din_i;
    end

    // Registered read port, returns old data on a same-address write
    always_ff @(posedge clk_i) begin
        if (!rst_ni) dout_q <= '0;
        else         dout_q <= mem[rd_addr_i];
    end

    assign dout_o     = dout_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign wr_count_o = wr_count_q;
endmodule

// File: tb/tb_sample_capture_ram.sv
// tb_sample_capture_ram: scoreboard bench for the triggered capture RAM
module tb_sample_capture_ram;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, arm = 1'b0, trig = 1'b0, din_valid = 1'b0;
    logic [7:0] din = '0, rd_addr = '0;
    logic [7:0] dout;
    logic       busy, done;
    logic [8:0] wr_count;
    int         cyc = 0;
    int         total = 0, bad = 0;

    typedef struct {
        string name;
        int    kind;
        int    val;
        int    cyc;
    } exp_t;
    exp_t sb[$];

    sample_capture_ram #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .trig_i(trig), .din_valid_i(din_valid),
        .din_i(din), .rd_addr_i(rd_addr), .dout_o(dout), .busy_o(busy), .done_o(done),
        .wr_count_o(wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on each falling edge, pop expectations due this cycle and compare
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            int   act;
            e = sb.pop_front();
            act = (e.kind == 0) ? int'(busy) : (e.kind == 1) ? int'(done) :
                  (e.kind == 2) ? int'(wr_count) : int'(dout);
            total++;
            if (e.cyc != cyc || act != e.val) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string n, input int k, input int v);
        exp_t e;
        e.name = n; e.kind = k; e.val = v; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic expect_st(input string n, input int b, input int d, input int c);
        expect_v({n, "_busy"}, 0, b);
        expect_v({n, "_done"}, 1, d);
        expect_v({n, "_wrcnt"}, 2, c);
    endtask

    // Full 256-sample capture of a constant value, starting from ARMED
    task automatic capture_const(input logic [7:0] v, input string n);
        for (int i = 0; i < 256; i++) begin
            trig = (i == 0); din_valid = 1'b1; din = v;
            tick();
        end
        trig = 1'b0; din_valid = 1'b0;
        expect_st(n, 0, 1, 256);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset
        rst_n = 1'b0;
        tick(); tick();
        expect_v("rst_dout", 3, 0);
        expect_st("rst", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        expect_st("post_rst", 0, 0, 0);

        // 2: ramp capture
        arm = 1'b1; tick(); arm = 1'b0;
        expect_st("armed", 1, 0, 0);
        for (int i = 0; i < 256; i++) begin
            trig = (i == 0); din_valid = 1'b1; din = 8'(i);
            tick();
            if (i < 255) expect_st("ramp", 1, 0, i + 1);
            else         expect_st("ramp_end", 0, 1, 256);
        end
        trig = 1'b0; din_valid = 1'b0;
        rd_addr = 8'h10; tick(); expect_v("rd_10", 3, 8'h10);
        rd_addr = 8'hFF; tick(); expect_v("rd_ff", 3, 8'hFF);

        // 3: alternate-cycle valid capture
        arm = 1'b1; tick(); arm = 1'b0;
        expect_st("alt_arm", 1, 0, 0);
        for (int j = 0; j < 511; j++) begin
            trig = (j == 0);
            din_valid = (j % 2 == 0);
            din = din_valid ? (8'(j / 2) ^ 8'h5A) : 8'hEE;
            tick();
            if (j < 510) expect_st("alt", 1, 0, j / 2 + 1);
            else         expect_st("alt_end", 0, 1, 256);
        end
        trig = 1'b0; din_valid = 1'b0;
        for (int k = 0; k < 256; k++) begin
            rd_addr = 8'(k); tick();
            expect_v("alt_rd", 3, k ^ 8'h5A);
        end

        // 4: ignored inputs
        trig = 1'b1; tick(); trig = 1'b0;
        expect_st("trig_in_done", 0, 1, 256);
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        trig = 1'b1; din_valid = 1'b1; tick(); trig = 1'b0; din_valid = 1'b0;
        expect_st("trig_in_idle", 0, 0, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        din_valid = 1'b1; tick(); din_valid = 1'b0;
        expect_st("valid_no_trig", 1, 0, 0);
        for (int i = 0; i < 256; i++) begin
            trig = (i == 0); din_valid = 1'b1; din = 8'h33;
            arm = (i == 3);
            tick();
            if (i < 255) expect_st("arm_in_cap", 1, 0, i + 1);
        end
        trig = 1'b0; din_valid = 1'b0; arm = 1'b0;
        expect_st("cap33_end", 0, 1, 256);
        arm = 1'b1; tick(); arm = 1'b0;
        expect_st("arm_in_done", 1, 0, 0);

        // 5: reset mid-capture keeps RAM
        for (int i = 0; i < 100; i++) begin
            trig = (i == 0); din_valid = 1'b1; din = 8'(i + 8'h40);
            tick();
        end
        trig = 1'b0; din_valid = 1'b0;
        expect_st("before_rst", 1, 0, 100);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        expect_st("mid_rst", 0, 0, 0);
        for (int k = 0; k < 101; k++) begin
            rd_addr = 8'(k); tick();
            expect_v("keep_rd", 3, (k < 100) ? k + 8'h40 : 8'h33);
        end
        arm = 1'b1; tick(); arm = 1'b0;
        capture_const(8'hAA, "capAA");
        for (int k = 0; k < 256; k++) begin
            rd_addr = 8'(k); tick();
            expect_v("aa_rd", 3, 8'hAA);
        end

        // 6: read-during-write returns old data
        arm = 1'b1; tick(); arm = 1'b0;
        capture_const(8'h11, "cap11");
        arm = 1'b1; tick(); arm = 1'b0;
        rd_addr = 8'h00; trig = 1'b1; din_valid = 1'b1; din = 8'h22;
        tick();
        trig = 1'b0; din_valid = 1'b0;
        expect_v("rdw_old", 3, 8'h11);
        tick();
        expect_v("rdw_new", 3, 8'h22);

        tick(); tick(); tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
